// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master transfer engine.
package spi_pkg;

  localparam int unsigned DEF_N       = 5;
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_DW      = 8;

  // Per-bit fill values, replicated to the word width by the engine
  localparam logic FILL_1S = 1'b1;
  localparam logic FILL_0S = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV clocks while run is high.
// The ticks flag the cycle whose closing edge makes sclk rise or fall.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master engine: shifts n_tx_end+1 words MSB first from the TX
// buffer, writes each received word to the RX buffer, then pulses wr2_c.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic          cs_ctrl,
  input  logic          all_1s,
  input  logic          all_0s,
  input  logic [N:0]    n_tx_end,
  output logic [N:0]    tx_addr,
  input  logic [DW-1:0] tx_data,
  output logic          rx_wr,
  output logic [N:0]    rx_addr,
  output logic [DW-1:0] rx_data,
  output logic          wr2_c,
  output logic          hold_ctrl,
  output logic [N+1:0]  n_rx_end,
  output logic          busy,
  output logic          sclk,
  output logic          mosi,
  input  logic          miso,
  output logic          cs
);

  localparam int unsigned BW = $clog2(DW + 1);

  state_t        state;
  logic [N:0]    last_q;
  logic [N:0]    byte_cnt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] fill_byte;
  logic [BW-1:0] bit_cnt;
  logic          run;
  logic          rise_tick;
  logic          fall_tick;

  // Chip select is software-owned; the engine never gates it
  assign cs  = cs_ctrl;
  assign run = (state == ST_SHIFT);

  always_comb begin
    fill_byte = tx_data;
    if (all_1s)      fill_byte = {DW{FILL_1S}};
    else if (all_0s) fill_byte = {DW{FILL_0S}};
  end

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // One shift register serves both directions: MSB drives mosi, miso enters at the LSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      last_q    <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx_addr   <= '0;
      rx_wr     <= 1'b0;
      rx_addr   <= '0;
      rx_data   <= '0;
      wr2_c     <= 1'b0;
      hold_ctrl <= 1'b0;
      n_rx_end  <= '0;
      busy      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      rx_wr     <= 1'b0;
      hold_ctrl <= 1'b0;
      wr2_c     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send) begin
            last_q   <= n_tx_end;
            byte_cnt <= '0;
            n_rx_end <= '0;
            tx_addr  <= '0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          shreg   <= fill_byte;
          mosi    <= fill_byte[DW-1];
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rise_tick) begin
            shreg   <= {shreg[DW-2:0], miso};
            bit_cnt <= bit_cnt + BW'(1);
          end
          if (fall_tick) begin
            if (bit_cnt == BW'(DW)) begin
              rx_wr     <= 1'b1;
              rx_addr   <= byte_cnt;
              rx_data   <= shreg;
              hold_ctrl <= 1'b1;
              state     <= ST_STORE;
            end else begin
              mosi <= shreg[DW-1];
            end
          end
        end
        ST_STORE: begin
          n_rx_end <= (N+2)'(byte_cnt) + (N+2)'(1);
          if (byte_cnt == last_q) begin
            wr2_c <= 1'b1;
            state <= ST_DONE;
          end else begin
            byte_cnt <= byte_cnt + (N+1)'(1);
            tx_addr  <= byte_cnt + (N+1)'(1);
            state    <= ST_LOAD;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: vector table plus reset, send-drop
// and full-length transfer sequences, checked against a TX memory model.
module tb_spi_master_engine;

  localparam int unsigned N       = 5;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned MAXB    = 1 << (N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          send;
  logic          cs_ctrl;
  logic          all_1s;
  logic          all_0s;
  logic [N:0]    n_tx_end;
  logic [N:0]    tx_addr;
  logic [DW-1:0] tx_data;
  logic          rx_wr;
  logic [N:0]    rx_addr;
  logic [DW-1:0] rx_data;
  logic          wr2_c;
  logic          hold_ctrl;
  logic [N+1:0]  n_rx_end;
  logic          busy;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs;

  logic [1:0]    miso_mode = 2'd0;
  logic [DW-1:0] tx_mem [MAXB];

  int n_checks = 0;
  int n_fail   = 0;

  spi_master_engine #(.N(N), .CLK_DIV(CLK_DIV), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .cs_ctrl   (cs_ctrl),
    .all_1s    (all_1s),
    .all_0s    (all_0s),
    .n_tx_end  (n_tx_end),
    .tx_addr   (tx_addr),
    .tx_data   (tx_data),
    .rx_wr     (rx_wr),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .wr2_c     (wr2_c),
    .hold_ctrl (hold_ctrl),
    .n_rx_end  (n_rx_end),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs        (cs)
  );

  always #5 clk = ~clk;

  // TX buffer model with one cycle of read latency
  always @(posedge clk) tx_data <= tx_mem[tx_addr];

  // Slave model: 0 = loopback, 1 = constant high, 2 = constant low
  always_comb begin
    miso = 1'b0;
    if (miso_mode == 2'd0)      miso = mosi;
    else if (miso_mode == 2'd1) miso = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: counts strobes, rebuilds mosi words, checks SCLK timing
  int            cyc = 0, rx_cnt = 0, hold_cnt = 0, wr2_cnt = 0, rise_cnt = 0;
  int            byte_idx = 0, bitn = 0, hi_len = 0, last_rise = 0;
  logic          prev_sclk = 1'b0, prev_busy = 1'b0, hold_pend = 1'b0;
  logic [DW-1:0] mbyte = '0;
  logic [DW-1:0] rx_mem   [MAXB];
  logic [DW-1:0] mosi_mem [MAXB];

  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) begin
      byte_idx = 0;
      bitn     = 0;
    end
    if (hold_pend) chk("n_rx_end_step", longint'(n_rx_end), longint'(byte_idx));
    hold_pend = 1'b0;
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      if (bitn != 0) chk("sclk_period", longint'(cyc - last_rise), longint'(2 * CLK_DIV));
      last_rise = cyc;
      hi_len    = 1;
      mbyte     = {mbyte[DW-2:0], mosi};
      bitn++;
      if (bitn == DW) begin
        mosi_mem[byte_idx] = mbyte;
        bitn = 0;
      end
    end else if (sclk) begin
      hi_len++;
    end
    if (!sclk && prev_sclk && busy) chk("sclk_high_len", longint'(hi_len), longint'(CLK_DIV));
    if (rx_wr) begin
      rx_cnt++;
      chk("rx_addr", longint'(rx_addr), longint'(byte_idx));
      chk("hold_with_wr", longint'(hold_ctrl), 1);
      rx_mem[rx_addr] = rx_data;
      byte_idx++;
      hold_pend = 1'b1;
    end
    if (hold_ctrl) hold_cnt++;
    if (wr2_c) wr2_cnt++;
    prev_sclk = sclk;
    prev_busy = busy;
  end

  typedef struct packed {
    logic [N:0]  n_end;
    logic        a1;
    logic        a0;
    logic [1:0]  mode;
    logic [31:0] tx;
    logic [31:0] rx;
    logic [31:0] mo;
  } vec_t;

  function automatic logic [31:0] b4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  // Plays the control register: send stays up until wr2_c clears it
  task automatic run_xfer(input logic [N:0] n_end, input logic a1, input logic a0,
                          input logic [1:0] mode, input bit drop);
    int  budget;
    int  c;
    bit  seen;
    n_tx_end  = n_end;
    all_1s    = a1;
    all_0s    = a0;
    miso_mode = mode;
    send      = 1'b1;
    seen      = 1'b0;
    c         = 0;
    budget    = (int'(n_end) + 1) * (2 * DW * CLK_DIV + 3) + 20;
    while (c < budget && !seen) begin
      @(negedge clk);
      if (drop && busy) send = 1'b0;
      if (drop && (c % 50) == 25) begin
        cs_ctrl = ~cs_ctrl;
        #1 chk("cs_follow", longint'(cs), longint'(cs_ctrl));
      end
      if (wr2_c) begin
        seen = 1'b1;
        send = 1'b0;
      end
      c++;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout: no wr2_c within %0d cycles", budget);
      send = 1'b0;
    end
  endtask

  task automatic apply_vec(input vec_t v, input bit drop);
    int r0, h0, w0, s0, nb;
    nb = int'(v.n_end) + 1;
    for (int i = 0; i < nb; i++) tx_mem[i] = v.tx[i*8 +: 8];
    r0 = rx_cnt; h0 = hold_cnt; w0 = wr2_cnt; s0 = rise_cnt;
    run_xfer(v.n_end, v.a1, v.a0, v.mode, drop);
    repeat (6) @(negedge clk);
    chk("rx_wr_count",   longint'(rx_cnt - r0),   longint'(nb));
    chk("hold_count",    longint'(hold_cnt - h0), longint'(nb));
    chk("wr2_count",     longint'(wr2_cnt - w0),  1);
    chk("sclk_pulses",   longint'(rise_cnt - s0), longint'(nb * DW));
    chk("n_rx_end_hold", longint'(n_rx_end),      longint'(nb));
    chk("busy_idle",     longint'(busy),          0);
    for (int i = 0; i < nb; i++) begin
      chk("rx_byte",   longint'(rx_mem[i]),   longint'(v.rx[i*8 +: 8]));
      chk("mosi_byte", longint'(mosi_mem[i]), longint'(v.mo[i*8 +: 8]));
    end
  endtask

  vec_t vecs [6];

  initial begin
    int r0, w0, h0, s0, c;

    vecs[0] = '{n_end: 6'd0, a1: 1'b0, a0: 1'b0, mode: 2'd0,
                tx: b4(8'hA5, 8'h00, 8'h00, 8'h00), rx: b4(8'hA5, 8'h00, 8'h00, 8'h00),
                mo: b4(8'hA5, 8'h00, 8'h00, 8'h00)};
    vecs[1] = '{n_end: 6'd3, a1: 1'b0, a0: 1'b0, mode: 2'd0,
                tx: b4(8'h01, 8'h80, 8'h3C, 8'hFF), rx: b4(8'h01, 8'h80, 8'h3C, 8'hFF),
                mo: b4(8'h01, 8'h80, 8'h3C, 8'hFF)};
    vecs[2] = '{n_end: 6'd1, a1: 1'b1, a0: 1'b1, mode: 2'd0,
                tx: b4(8'h12, 8'h34, 8'h00, 8'h00), rx: b4(8'hFF, 8'hFF, 8'h00, 8'h00),
                mo: b4(8'hFF, 8'hFF, 8'h00, 8'h00)};
    vecs[3] = '{n_end: 6'd1, a1: 1'b0, a0: 1'b1, mode: 2'd0,
                tx: b4(8'h12, 8'h34, 8'h00, 8'h00), rx: b4(8'h00, 8'h00, 8'h00, 8'h00),
                mo: b4(8'h00, 8'h00, 8'h00, 8'h00)};
    vecs[4] = '{n_end: 6'd2, a1: 1'b0, a0: 1'b0, mode: 2'd1,
                tx: b4(8'h5A, 8'hC3, 8'h0F, 8'h00), rx: b4(8'hFF, 8'hFF, 8'hFF, 8'h00),
                mo: b4(8'h5A, 8'hC3, 8'h0F, 8'h00)};
    vecs[5] = '{n_end: 6'd1, a1: 1'b1, a0: 1'b0, mode: 2'd2,
                tx: b4(8'h00, 8'h00, 8'h00, 8'h00), rx: b4(8'h00, 8'h00, 8'h00, 8'h00),
                mo: b4(8'hFF, 8'hFF, 8'h00, 8'h00)};

    rst = 1'b0; send = 1'b0; cs_ctrl = 1'b1; all_1s = 1'b0; all_0s = 1'b0;
    n_tx_end = '0;
    for (int i = 0; i < int'(MAXB); i++) tx_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",     longint'(sclk),      0);
    chk("rst_mosi",     longint'(mosi),      0);
    chk("rst_busy",     longint'(busy),      0);
    chk("rst_rx_wr",    longint'(rx_wr),     0);
    chk("rst_wr2_c",    longint'(wr2_c),     0);
    chk("rst_hold",     longint'(hold_ctrl), 0);
    chk("rst_n_rx_end", longint'(n_rx_end),  0);
    chk("rst_tx_addr",  longint'(tx_addr),   0);
    chk("rst_cs",       longint'(cs),        1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) apply_vec(vecs[k], 1'b0);

    // Async reset in the middle of the third word, then a clean restart
    for (int i = 0; i < 4; i++) tx_mem[i] = vecs[1].tx[i*8 +: 8];
    n_tx_end = 6'd3; all_1s = 1'b0; all_0s = 1'b0; miso_mode = 2'd0;
    send = 1'b1;
    c = 0;
    while (c < 2000 && !(busy && byte_idx == 2 && bitn == 5)) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (c >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_point_timeout: bit 5 of word 2 not reached");
    end
    r0 = rx_cnt; w0 = wr2_cnt;
    rst = 1'b0;
    #1;
    chk("arst_sclk",     longint'(sclk),     0);
    chk("arst_busy",     longint'(busy),     0);
    chk("arst_rx_wr",    longint'(rx_wr),    0);
    chk("arst_n_rx_end", longint'(n_rx_end), 0);
    send = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_rx_wr", longint'(rx_cnt - r0),  0);
    chk("arst_no_wr2",   longint'(wr2_cnt - w0), 0);
    chk("arst_idle",     longint'(busy),         0);
    apply_vec(vecs[1], 1'b0);

    // Send dropped mid-transfer while cs_ctrl toggles
    apply_vec(vecs[4], 1'b1);
    cs_ctrl = 1'b0;
    #1 chk("cs_low", longint'(cs), 0);
    cs_ctrl = 1'b1;
    #1 chk("cs_high", longint'(cs), 1);

    // Full-length transfer: 2^(N+1) words with miso held high
    for (int i = 0; i < int'(MAXB); i++) tx_mem[i] = 8'(i * 7 + 3);
    r0 = rx_cnt; h0 = hold_cnt; w0 = wr2_cnt; s0 = rise_cnt;
    run_xfer(6'd63, 1'b0, 1'b0, 2'd1, 1'b0);
    repeat (6) @(negedge clk);
    chk("full_rx_wr",    longint'(rx_cnt - r0),   longint'(MAXB));
    chk("full_hold",     longint'(hold_cnt - h0), longint'(MAXB));
    chk("full_wr2",      longint'(wr2_cnt - w0),  1);
    chk("full_sclk",     longint'(rise_cnt - s0), longint'(MAXB * DW));
    chk("full_n_rx_end", longint'(n_rx_end),      longint'(MAXB));
    for (int i = 0; i < int'(MAXB); i++) begin
      chk("full_rx_byte",   longint'(rx_mem[i]),   64'hFF);
      chk("full_mosi_byte", longint'(mosi_mem[i]), longint'(tx_mem[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
